// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath with a 16-entry GPR file, ALU with 64-bit Z,
// I/O port registers, a CON branch flag and a 512-word RAM, driven by per-cycle strobes.
module data_path #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              INPORTin,
  input  logic              Zin,
  input  logic              Yin,
  input  logic              MARin,
  input  logic              IRin,
  input  logic              CONin,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              ZHIout,
  input  logic              ZLOout,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              INPORTout,
  input  logic              Cout,
  input  logic              Yout,
  input  logic              OUTPORTout,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              Read,
  input  logic              IncPC,
  input  logic              write,
  output logic [DATA_W-1:0] busMuxOut,
  output logic [4:0]        encoderOut,
  output logic              CON,
  output logic [DATA_W-1:0] BusMuxInR0,
  output logic [DATA_W-1:0] BusMuxInR1,
  output logic [DATA_W-1:0] BusMuxInR2,
  output logic [DATA_W-1:0] BusMuxInR3,
  output logic [DATA_W-1:0] BusMuxInR4,
  output logic [DATA_W-1:0] BusMuxInR5,
  output logic [DATA_W-1:0] BusMuxInR6,
  output logic [DATA_W-1:0] BusMuxInR7,
  output logic [DATA_W-1:0] BusMuxInR8,
  output logic [DATA_W-1:0] BusMuxInR9,
  output logic [DATA_W-1:0] BusMuxInR10,
  output logic [DATA_W-1:0] BusMuxInR11,
  output logic [DATA_W-1:0] BusMuxInR12,
  output logic [DATA_W-1:0] BusMuxInR13,
  output logic [DATA_W-1:0] BusMuxInR14,
  output logic [DATA_W-1:0] BusMuxInR15,
  output logic [DATA_W-1:0] BusMuxInHI,
  output logic [DATA_W-1:0] BusMuxInLO,
  output logic [DATA_W-1:0] BusMuxInZhi,
  output logic [DATA_W-1:0] BusMuxInZlo,
  output logic [DATA_W-1:0] BusMuxInPC,
  output logic [DATA_W-1:0] BusMuxInMDR,
  output logic [DATA_W-1:0] BusMuxInInport,
  output logic [DATA_W-1:0] BusMuxInOutport,
  output logic [DATA_W-1:0] BusMuxInY,
  output logic [DATA_W-1:0] IRregister,
  output logic [DATA_W-1:0] Cregister,
  output logic [ADDR_W-1:0] marToRam
);
  localparam int NSRC = 25;

  logic [DATA_W-1:0]        r_gpr [16];
  logic [DATA_W-1:0]        r_pc, r_ir, r_mdr, r_hi, r_lo, r_y, r_zhi, r_zlo, r_inport, r_outport;
  logic [ADDR_W-1:0]        r_mar;
  logic                     r_con;
  logic [DATA_W-1:0]        r_mem [0:(1<<ADDR_W)-1];

  logic                     w_sel_valid;
  logic [3:0]               w_sel_idx;
  logic [DATA_W-1:0]        w_c, w_bus, w_ror, w_rol;
  logic [4:0]               w_enc, w_op, w_sh;
  logic [5:0]               w_sh_inv;
  logic [NSRC-1:0]          w_req;
  logic [DATA_W-1:0]        w_src [NSRC];
  logic [2*DATA_W-1:0]      w_alu;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [DATA_W-1:0] w_quo, w_rem;
  logic                     w_cond;

  // Register-field select: Gra beats Grb beats Grc.
  always_comb begin
    w_sel_valid = Gra | Grb | Grc;
    if (Gra)      w_sel_idx = r_ir[26:23];
    else if (Grb) w_sel_idx = r_ir[22:19];
    else if (Grc) w_sel_idx = r_ir[18:15];
    else          w_sel_idx = 4'd0;
  end

  assign w_c = {{(DATA_W-19){r_ir[18]}}, r_ir[18:0]};

  // Per-code request and value table; BAout reads R0 as zero for base addressing.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_req[i] = w_sel_valid & (Rout | BAout) & (w_sel_idx == 4'(i));
      w_src[i] = r_gpr[i];
    end
    if (BAout && !Rout) w_src[0] = {DATA_W{1'b0}};
    else                w_src[0] = r_gpr[0];
    w_req[16] = HIout;     w_src[16] = r_hi;
    w_req[17] = LOout;     w_src[17] = r_lo;
    w_req[18] = ZHIout;    w_src[18] = r_zhi;
    w_req[19] = ZLOout;    w_src[19] = r_zlo;
    w_req[20] = PCout;     w_src[20] = r_pc;
    w_req[21] = MDRout;    w_src[21] = r_mdr;
    w_req[22] = INPORTout; w_src[22] = r_inport;
    w_req[23] = Cout;      w_src[23] = w_c;
    w_req[24] = Yout;      w_src[24] = r_y;
  end

  // Bus mux: scanning downward lets the lowest active code overwrite the rest.
  always_comb begin
    w_bus = {DATA_W{1'b0}};
    w_enc = 5'd31;
    for (int i = NSRC - 1; i >= 0; i--) begin
      w_bus = w_req[i] ? w_src[i] : w_bus;
      w_enc = w_req[i] ? 5'(i) : w_enc;
    end
  end

  assign w_op     = r_ir[31:27];
  assign w_sh     = w_bus[4:0];
  assign w_sh_inv = 6'(DATA_W) - {1'b0, w_sh};
  assign w_ror    = (r_y >> w_sh) | (r_y << w_sh_inv);
  assign w_rol    = (r_y << w_sh) | (r_y >> w_sh_inv);
  assign w_prod   = $signed({{DATA_W{r_y[DATA_W-1]}}, r_y}) * $signed({{DATA_W{w_bus[DATA_W-1]}}, w_bus});
  assign w_quo    = $signed(r_y) / $signed(w_bus);
  assign w_rem    = $signed(r_y) % $signed(w_bus);

  // ALU: A=Y, B=bus; IncPC overrides the opcode.
  always_comb begin
    w_alu = {(2*DATA_W){1'b0}};
    if (IncPC) begin
      w_alu[DATA_W-1:0] = w_bus + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      case (w_op)
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b10010: w_alu[DATA_W-1:0] = r_y + w_bus;
        5'b00100:           w_alu[DATA_W-1:0] = r_y - w_bus;
        5'b00101, 5'b01100: w_alu[DATA_W-1:0] = r_y & w_bus;
        5'b00110, 5'b01101: w_alu[DATA_W-1:0] = r_y | w_bus;
        5'b00111:           w_alu[DATA_W-1:0] = r_y >> w_sh;
        5'b01000:           w_alu[DATA_W-1:0] = r_y << w_sh;
        5'b01001:           w_alu[DATA_W-1:0] = w_ror;
        5'b01010:           w_alu[DATA_W-1:0] = w_rol;
        5'b01110:           w_alu = w_prod;
        5'b01111: begin
          if (w_bus == {DATA_W{1'b0}}) w_alu = {(2*DATA_W){1'b0}};
          else                         w_alu = {w_rem, w_quo};
        end
        5'b10000:           w_alu[DATA_W-1:0] = {DATA_W{1'b0}} - w_bus;
        5'b10001:           w_alu[DATA_W-1:0] = ~w_bus;
        default:            w_alu[DATA_W-1:0] = w_bus;
      endcase
    end
  end

  // Branch condition evaluated on the bus value.
  always_comb begin
    case (r_ir[20:19])
      2'b00:   w_cond = (w_bus == {DATA_W{1'b0}});
      2'b01:   w_cond = (w_bus != {DATA_W{1'b0}});
      2'b10:   w_cond = ~w_bus[DATA_W-1];
      2'b11:   w_cond = w_bus[DATA_W-1];
      default: w_cond = 1'b0;
    endcase
  end

  // Architectural registers; clear wipes everything except the RAM.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= {DATA_W{1'b0}};
      r_pc <= {DATA_W{1'b0}};  r_ir <= {DATA_W{1'b0}};  r_mar <= {ADDR_W{1'b0}};
      r_mdr <= {DATA_W{1'b0}}; r_hi <= {DATA_W{1'b0}};  r_lo <= {DATA_W{1'b0}};
      r_y <= {DATA_W{1'b0}};   r_zhi <= {DATA_W{1'b0}}; r_zlo <= {DATA_W{1'b0}};
      r_inport <= {DATA_W{1'b0}}; r_outport <= {DATA_W{1'b0}}; r_con <= 1'b0;
    end else begin
      if (Rin && w_sel_valid) r_gpr[w_sel_idx] <= w_bus;
      if (PCin)       r_pc      <= w_bus;
      if (IRin)       r_ir      <= w_bus;
      if (MARin)      r_mar     <= w_bus[ADDR_W-1:0];
      if (MDRin)      r_mdr     <= Read ? r_mem[r_mar] : w_bus;
      if (HIin)       r_hi      <= w_bus;
      if (LOin)       r_lo      <= w_bus;
      if (Yin)        r_y       <= w_bus;
      if (INPORTin)   r_inport  <= w_bus;
      if (OUTPORTout) r_outport <= w_bus;
      if (CONin)      r_con     <= w_cond;
      if (Zin) begin
        r_zhi <= w_alu[2*DATA_W-1:DATA_W];
        r_zlo <= w_alu[DATA_W-1:0];
      end
    end
  end

  // RAM write port: MDR stored at MAR.
  always_ff @(posedge Clock) begin
    if (write) r_mem[r_mar] <= r_mdr;
  end

  assign busMuxOut = w_bus;
  assign encoderOut = w_enc;
  assign CON = r_con;
  assign BusMuxInR0 = r_gpr[0];   assign BusMuxInR1 = r_gpr[1];
  assign BusMuxInR2 = r_gpr[2];   assign BusMuxInR3 = r_gpr[3];
  assign BusMuxInR4 = r_gpr[4];   assign BusMuxInR5 = r_gpr[5];
  assign BusMuxInR6 = r_gpr[6];   assign BusMuxInR7 = r_gpr[7];
  assign BusMuxInR8 = r_gpr[8];   assign BusMuxInR9 = r_gpr[9];
  assign BusMuxInR10 = r_gpr[10]; assign BusMuxInR11 = r_gpr[11];
  assign BusMuxInR12 = r_gpr[12]; assign BusMuxInR13 = r_gpr[13];
  assign BusMuxInR14 = r_gpr[14]; assign BusMuxInR15 = r_gpr[15];
  assign BusMuxInHI = r_hi;
  assign BusMuxInLO = r_lo;
  assign BusMuxInZhi = r_zhi;
  assign BusMuxInZlo = r_zlo;
  assign BusMuxInPC = r_pc;
  assign BusMuxInMDR = r_mdr;
  assign BusMuxInInport = r_inport;
  assign BusMuxInOutport = r_outport;
  assign BusMuxInY = r_y;
  assign IRregister = r_ir;
  assign Cregister = w_c;
  assign marToRam = r_mar;
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: directed instruction sequences plus random control strobes,
// all checked against a behavioural model of the datapath kept in the bench.
module tb_data_path;
  logic Clock, clear;
  logic HIin, LOin, PCin, MDRin, INPORTin, Zin, Yin, MARin, IRin, CONin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout, Yout, OUTPORTout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write;
  logic [31:0] busMuxOut, o_r [16];
  logic [31:0] o_hi, o_lo, o_zhi, o_zlo, o_pc, o_mdr, o_in, o_out, o_y, o_ir, o_c;
  logic [4:0]  encoderOut;
  logic [8:0]  marToRam;
  logic        CON;

  typedef struct packed {
    logic hi_in, lo_in, pc_in, mdr_in, inport_in, z_in, y_in, mar_in, ir_in, con_in;
    logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out, y_out, outport_out;
    logic gra, grb, grc, r_in, r_out, ba_out, rd, inc_pc, wr;
  } ctl_t;

  // behavioural model state
  logic [31:0] m_gpr [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo, m_in, m_out;
  logic        m_con;
  logic [31:0] m_mem [512];
  int n_cmp = 0, n_mis = 0;

  data_path dut (
    .Clock(Clock), .clear(clear),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .INPORTin(INPORTin), .Zin(Zin),
    .Yin(Yin), .MARin(MARin), .IRin(IRin), .CONin(CONin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Cout(Cout), .Yout(Yout), .OUTPORTout(OUTPORTout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .IncPC(IncPC), .write(write),
    .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
    .BusMuxInR0(o_r[0]), .BusMuxInR1(o_r[1]), .BusMuxInR2(o_r[2]), .BusMuxInR3(o_r[3]),
    .BusMuxInR4(o_r[4]), .BusMuxInR5(o_r[5]), .BusMuxInR6(o_r[6]), .BusMuxInR7(o_r[7]),
    .BusMuxInR8(o_r[8]), .BusMuxInR9(o_r[9]), .BusMuxInR10(o_r[10]), .BusMuxInR11(o_r[11]),
    .BusMuxInR12(o_r[12]), .BusMuxInR13(o_r[13]), .BusMuxInR14(o_r[14]), .BusMuxInR15(o_r[15]),
    .BusMuxInHI(o_hi), .BusMuxInLO(o_lo), .BusMuxInZhi(o_zhi), .BusMuxInZlo(o_zlo),
    .BusMuxInPC(o_pc), .BusMuxInMDR(o_mdr), .BusMuxInInport(o_in), .BusMuxInOutport(o_out),
    .BusMuxInY(o_y), .IRregister(o_ir), .Cregister(o_c), .marToRam(marToRam)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input ctl_t c);
    HIin = c.hi_in; LOin = c.lo_in; PCin = c.pc_in; MDRin = c.mdr_in; INPORTin = c.inport_in;
    Zin = c.z_in; Yin = c.y_in; MARin = c.mar_in; IRin = c.ir_in; CONin = c.con_in;
    HIout = c.hi_out; LOout = c.lo_out; ZHIout = c.zhi_out; ZLOout = c.zlo_out; PCout = c.pc_out;
    MDRout = c.mdr_out; INPORTout = c.inport_out; Cout = c.c_out; Yout = c.y_out;
    OUTPORTout = c.outport_out; Gra = c.gra; Grb = c.grb; Grc = c.grc; Rin = c.r_in;
    Rout = c.r_out; BAout = c.ba_out; Read = c.rd; IncPC = c.inc_pc; write = c.wr;
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    dut.r_mem[a] <= v;
    m_mem[a] = v;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_gpr[i] = 32'd0;
    m_pc = 32'd0; m_ir = 32'd0; m_mar = 32'd0; m_mdr = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
    m_y = 32'd0; m_zhi = 32'd0; m_zlo = 32'd0; m_in = 32'd0; m_out = 32'd0; m_con = 1'b0;
  endtask

  function automatic int sel_idx(input ctl_t c);
    if (c.gra) return int'(m_ir[26:23]);
    if (c.grb) return int'(m_ir[22:19]);
    if (c.grc) return int'(m_ir[18:15]);
    return -1;
  endfunction

  function automatic logic [31:0] c_val();
    return {{13{m_ir[18]}}, m_ir[18:0]};
  endfunction

  // Bus value: the first listed driver, in code order, that is enabled.
  function automatic void m_bus(input ctl_t c, output logic [31:0] v, output logic [4:0] code);
    int s;
    logic [31:0] vals [25];
    bit en [25];
    s = sel_idx(c);
    for (int i = 0; i < 16; i++) begin
      en[i] = (s == i) && (c.r_out || c.ba_out);
      vals[i] = (i == 0 && c.ba_out && !c.r_out) ? 32'd0 : m_gpr[i];
    end
    en[16] = c.hi_out;  vals[16] = m_hi;   en[17] = c.lo_out;     vals[17] = m_lo;
    en[18] = c.zhi_out; vals[18] = m_zhi;  en[19] = c.zlo_out;    vals[19] = m_zlo;
    en[20] = c.pc_out;  vals[20] = m_pc;   en[21] = c.mdr_out;    vals[21] = m_mdr;
    en[22] = c.inport_out; vals[22] = m_in; en[23] = c.c_out;     vals[23] = c_val();
    en[24] = c.y_out;   vals[24] = m_y;
    v = 32'd0; code = 5'd31;
    for (int i = 0; i < 25; i++) begin
      if (en[i]) begin
        v = vals[i]; code = 5'(i);
        break;
      end
    end
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic inc,
                                         input logic [4:0] op);
    logic [31:0] t;
    int sa, sb;
    if (inc) return {32'd0, b + 32'd1};
    sa = int'(a); sb = int'(b); t = a;
    case (int'(op))
      0, 1, 2, 3, 11, 18: return {32'd0, a + b};
      4:      return {32'd0, a - b};
      5, 12:  return {32'd0, a & b};
      6, 13:  return {32'd0, a | b};
      7:      return {32'd0, a >> b[4:0]};
      8:      return {32'd0, a << b[4:0]};
      9: begin
        for (int k = 0; k < int'(b[4:0]); k++) t = {t[0], t[31:1]};
        return {32'd0, t};
      end
      10: begin
        for (int k = 0; k < int'(b[4:0]); k++) t = {t[30:0], t[31]};
        return {32'd0, t};
      end
      14:     return 64'(longint'(sa) * longint'(sb));
      15: begin
        if (sb == 0) return 64'd0;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      16:     return {32'd0, 32'd0 - b};
      17:     return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 16; i++) check_val($sformatf("R%0d", i), o_r[i], m_gpr[i]);
    check_val("HI", o_hi, m_hi);     check_val("LO", o_lo, m_lo);
    check_val("ZHI", o_zhi, m_zhi);  check_val("ZLO", o_zlo, m_zlo);
    check_val("PC", o_pc, m_pc);     check_val("MDR", o_mdr, m_mdr);
    check_val("INPORT", o_in, m_in); check_val("OUTPORT", o_out, m_out);
    check_val("Y", o_y, m_y);        check_val("IR", o_ir, m_ir);
    check_val("C", o_c, c_val());
    check_val("MAR", {23'd0, marToRam}, {23'd0, m_mar[8:0]});
    check_val("CON", {31'd0, CON}, {31'd0, m_con});
  endtask

  // One clock with control set c: bus checked before the edge, state after.
  task automatic step(input ctl_t c);
    logic [31:0] bv, n_mdr;
    logic [4:0]  bc;
    logic [63:0] alu;
    logic        cond;
    int          s;
    drive(c);
    #2;
    m_bus(c, bv, bc);
    check_val("bus", busMuxOut, bv);
    check_val("enc", {27'd0, encoderOut}, {27'd0, bc});
    s = sel_idx(c);
    alu = m_alu(m_y, bv, c.inc_pc, m_ir[31:27]);
    case (m_ir[20:19])
      2'b00:   cond = (bv == 32'd0);
      2'b01:   cond = (bv != 32'd0);
      2'b10:   cond = (bv[31] == 1'b0);
      default: cond = (bv[31] == 1'b1);
    endcase
    n_mdr = c.rd ? m_mem[m_mar[8:0]] : bv;
    @(posedge Clock);
    #1;
    if (c.wr) m_mem[m_mar[8:0]] = m_mdr;
    if (c.r_in && s >= 0) m_gpr[s] = bv;
    if (c.pc_in) m_pc = bv;
    if (c.ir_in) m_ir = bv;
    if (c.mar_in) m_mar = bv;
    if (c.mdr_in) m_mdr = n_mdr;
    if (c.hi_in) m_hi = bv;
    if (c.lo_in) m_lo = bv;
    if (c.y_in) m_y = bv;
    if (c.inport_in) m_in = bv;
    if (c.outport_out) m_out = bv;
    if (c.con_in) m_con = cond;
    if (c.z_in) {m_zhi, m_zlo} = alu;
    check_regs();
  endtask

  task automatic fetch();
    ctl_t c;
    c = '0; c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; step(c);
    c = '0; c.zlo_out = 1'b1; c.pc_in = 1'b1; c.rd = 1'b1; c.mdr_in = 1'b1; step(c);
    c = '0; c.mdr_out = 1'b1; c.ir_in = 1'b1; step(c);
  endtask

  task automatic addr_calc();
    ctl_t c;
    c = '0; c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; step(c);
    c = '0; c.c_out = 1'b1; c.z_in = 1'b1; step(c);
    c = '0; c.zlo_out = 1'b1; c.mar_in = 1'b1; step(c);
  endtask

  task automatic ld();
    ctl_t c;
    fetch();
    addr_calc();
    c = '0; c.rd = 1'b1; c.mdr_in = 1'b1; step(c);
    c = '0; c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; step(c);
  endtask

  task automatic alu_rb_rc();
    ctl_t c;
    fetch();
    c = '0; c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; step(c);
    c = '0; c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; step(c);
  endtask

  initial begin
    ctl_t c;
    clear = 1'b1;
    drive('0);
    for (int a = 0; a < 512; a++) poke(a, $urandom);
    poke(0, 32'h00800075);  poke(32'h75, 32'h34);     // ld R1,0x75
    poke(1, 32'h00800076);  poke(32'h76, 32'h10);     // ld R1,0x76
    poke(2, 32'h01080045);  poke(32'h55, 32'hABCD);   // ld R2,0x45(R1)
    poke(3, 32'h00000077);  poke(32'h77, 32'h99);     // ld R0,0x77
    poke(4, 32'h01000045);  poke(32'h45, 32'h1234);   // ld R2,0x45(R0)
    poke(5, 32'h01800078);  poke(32'h78, 32'd7);      // ld R3
    poke(6, 32'h02000079);  poke(32'h79, 32'hFFFFFFFD); // ld R4 = -3
    poke(7, 32'h701A0000);                            // mul R3,R4
    poke(8, 32'h0200007A);  poke(32'h7A, 32'd2);      // ld R4 = 2
    poke(9, 32'h781A0000);                            // div R3,R4
    poke(10, 32'h781A8000);                           // div R3,R5 (R5 = 0)
    poke(11, 32'h0380007B); poke(32'h7B, 32'h55);     // ld R7
    poke(12, 32'h13800080); poke(32'h80, 32'h11);     // st 0x80,R7
    poke(13, 32'h0400007C); poke(32'h7C, 32'd5);      // ld R8 = 5
    poke(14, 32'h94080000);                           // branch, Ra=R8, cond nonzero
    #12;
    m_reset();
    check_regs();
    check_val("idle_enc", {27'd0, encoderOut}, 32'd31);
    clear = 1'b0;
    @(posedge Clock);
    #1;

    ld();
    check_val("ld1_PC", o_pc, 32'd1);
    check_val("ld1_IR", o_ir, 32'h00800075);
    check_val("ld1_MAR", {23'd0, marToRam}, 32'h75);
    check_val("ld1_R1", o_r[1], 32'h34);
    ld();
    ld();
    check_val("ld_idx_R2", o_r[2], 32'hABCD);
    ld();
    ld();
    check_val("ld_R0_R0", o_r[0], 32'h99);
    check_val("ld_ba_R2", o_r[2], 32'h1234);

    c = '0; c.pc_out = 1'b1; c.mdr_out = 1'b1;
    drive(c);
    #1;
    check_val("prio_enc", {27'd0, encoderOut}, 32'd20);
    check_val("prio_bus", busMuxOut, 32'd5);
    step(c);
    drive('0);
    #1;
    check_val("none_enc", {27'd0, encoderOut}, 32'd31);
    check_val("none_bus", busMuxOut, 32'd0);
    step('0);

    ld();
    ld();
    alu_rb_rc();
    check_val("mul_hi", o_zhi, 32'hFFFFFFFF);
    check_val("mul_lo", o_zlo, 32'hFFFFFFEB);
    ld();
    alu_rb_rc();
    check_val("div_lo", o_zlo, 32'd3);
    check_val("div_hi", o_zhi, 32'd1);
    alu_rb_rc();
    check_val("div0_lo", o_zlo, 32'd0);
    check_val("div0_hi", o_zhi, 32'd0);

    ld();
    fetch();
    addr_calc();
    c = '0; c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; step(c);
    c = '0; c.wr = 1'b1; step(c);
    c = '0; c.mdr_in = 1'b1; step(c);
    check_val("st_mdr_clr", o_mdr, 32'd0);
    c = '0; c.rd = 1'b1; c.mdr_in = 1'b1; step(c);
    check_val("st_mem80", o_mdr, 32'h55);

    ld();
    fetch();
    c = '0; c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; step(c);
    check_val("con_ne_5", {31'd0, CON}, 32'd1);
    c = '0; c.con_in = 1'b1; step(c);
    check_val("con_ne_0", {31'd0, CON}, 32'd0);

    clear = 1'b1;
    #1;
    m_reset();
    check_regs();
    clear = 1'b0;
    step('0);
    ld();
    check_val("post_clr_R1", o_r[1], 32'h34);
    check_val("post_clr_PC", o_pc, 32'd1);

    for (int n = 0; n < 400; n++) begin
      c = ctl_t'(29'($urandom & $urandom));
      step(c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
